// File: rtl/bios_host_pkg.sv
// Shared types and constants for the BIOS byte-stream command protocol.
package bios_host_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_BOOT  = 3'd1,
        OP_RST   = 3'd2,
        OP_WRITE = 3'd3,
        OP_READ  = 3'd4
    } bios_op_t;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 3;

    // Lowercase command-word letters
    localparam logic [BYTE_W-1:0] CH_LC_A = 8'h61;
    localparam logic [BYTE_W-1:0] CH_LC_B = 8'h62;
    localparam logic [BYTE_W-1:0] CH_LC_D = 8'h64;
    localparam logic [BYTE_W-1:0] CH_LC_E = 8'h65;
    localparam logic [BYTE_W-1:0] CH_LC_I = 8'h69;
    localparam logic [BYTE_W-1:0] CH_LC_N = 8'h6E;
    localparam logic [BYTE_W-1:0] CH_LC_O = 8'h6F;
    localparam logic [BYTE_W-1:0] CH_LC_P = 8'h70;
    localparam logic [BYTE_W-1:0] CH_LC_R = 8'h72;
    localparam logic [BYTE_W-1:0] CH_LC_S = 8'h73;
    localparam logic [BYTE_W-1:0] CH_LC_T = 8'h74;
    localparam logic [BYTE_W-1:0] CH_LC_W = 8'h77;

    // Reply bytes: acknowledges and error codes
    localparam logic [BYTE_W-1:0] CH_ACK_N = 8'h4E;
    localparam logic [BYTE_W-1:0] CH_ACK_B = 8'h42;
    localparam logic [BYTE_W-1:0] CH_ACK_R = 8'h52;
    localparam logic [BYTE_W-1:0] CH_ACK_W = 8'h57;
    localparam logic [BYTE_W-1:0] CH_ERR_0 = 8'h30;
    localparam logic [BYTE_W-1:0] CH_ERR_E = 8'h45;
    localparam logic [BYTE_W-1:0] CH_ERR_X = 8'h58;

    function automatic logic op_is_valid(input logic [2:0] op);
        return (op <= 3'd4);
    endfunction

    function automatic logic [BYTE_W-1:0] bios_ack(input bios_op_t op);
        case (op)
            OP_NOP:   return CH_ACK_N;
            OP_BOOT:  return CH_ACK_B;
            OP_RST:   return CH_ACK_R;
            OP_WRITE: return CH_ACK_W;
            OP_READ:  return CH_ACK_R;
            default:  return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/bios_host_if.sv
// Command, stream and result signals between the host initiator and its peers.
interface bios_host_if;
    logic [2:0] cmd_op;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_out_ready;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_in_ready;
    logic       rsp_valid;
    logic       rsp_ok;
    logic [7:0] rsp_code;
    logic       rsp_timeout;
    logic       busy;

    modport master (
        input  cmd_op, cmd_valid, i_out_ready, i_data, i_valid,
        output cmd_ready, o_data, o_valid, o_in_ready,
               rsp_valid, rsp_ok, rsp_code, rsp_timeout, busy
    );

    modport slave (
        output cmd_op, cmd_valid, i_out_ready, i_data, i_valid,
        input  cmd_ready, o_data, o_valid, o_in_ready,
               rsp_valid, rsp_ok, rsp_code, rsp_timeout, busy
    );
endinterface

// File: rtl/bios_cmd_rom.sv
// Command-word lookup: character at an index, last-character flag and expected ack.
module bios_cmd_rom
    import bios_host_pkg::*;
(
    input  bios_op_t          i_op,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [BYTE_W-1:0] o_char,
    output logic              o_last,
    output logic [BYTE_W-1:0] o_ack
);

    // Pure table decode; unused opcodes/indices yield 0x00
    always_comb begin
        o_char = 8'h00;
        o_last = 1'b0;
        o_ack  = bios_ack(i_op);
        case (i_op)
            OP_NOP: case (i_idx)
                3'd0: o_char = CH_LC_N;
                3'd1: o_char = CH_LC_O;
                3'd2: begin o_char = CH_LC_P; o_last = 1'b1; end
                default: ;
            endcase
            OP_BOOT: case (i_idx)
                3'd0: o_char = CH_LC_B;
                3'd1: o_char = CH_LC_O;
                3'd2: o_char = CH_LC_O;
                3'd3: begin o_char = CH_LC_T; o_last = 1'b1; end
                default: ;
            endcase
            OP_RST: case (i_idx)
                3'd0: o_char = CH_LC_R;
                3'd1: o_char = CH_LC_S;
                3'd2: begin o_char = CH_LC_T; o_last = 1'b1; end
                default: ;
            endcase
            OP_WRITE: case (i_idx)
                3'd0: o_char = CH_LC_W;
                3'd1: o_char = CH_LC_R;
                3'd2: o_char = CH_LC_I;
                3'd3: o_char = CH_LC_T;
                3'd4: begin o_char = CH_LC_E; o_last = 1'b1; end
                default: ;
            endcase
            OP_READ: case (i_idx)
                3'd0: o_char = CH_LC_R;
                3'd1: o_char = CH_LC_E;
                3'd2: o_char = CH_LC_A;
                3'd3: begin o_char = CH_LC_D; o_last = 1'b1; end
                default: ;
            endcase
            default: ;
        endcase
    end

endmodule

// File: rtl/bios_host.sv
// Host-side BIOS command initiator: send command word, await one-byte reply or timeout.
module bios_host
    import bios_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    bios_host_if.master  bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_RSP} state_t;

    state_t            r_state;
    bios_op_t          r_op;
    logic [IDX_W-1:0]  r_idx;
    logic              r_last;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cmd_ready;
    logic              r_busy;
    logic [BYTE_W-1:0] r_o_data;
    logic              r_o_valid;
    logic              r_o_in_ready;
    logic              r_rsp_valid;
    logic              r_rsp_ok;
    logic [BYTE_W-1:0] r_rsp_code;
    logic              r_rsp_timeout;

    bios_op_t          w_rom_op;
    logic [IDX_W-1:0]  w_rom_idx;
    logic [BYTE_W-1:0] w_char;
    logic              w_last;
    logic [BYTE_W-1:0] w_ack;

    // In IDLE look up the first char of the incoming opcode, otherwise the next char
    assign w_rom_op  = (r_state == S_IDLE) ? bios_op_t'(bus.cmd_op) : r_op;
    assign w_rom_idx = (r_state == S_IDLE) ? '0 : r_idx + IDX_W'(1);

    bios_cmd_rom u_rom (
        .i_op   (w_rom_op),
        .i_idx  (w_rom_idx),
        .o_char (w_char),
        .o_last (w_last),
        .o_ack  (w_ack)
    );

    // Main FSM with registered outputs; reset overrides clk_en
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_op          <= OP_NOP;
            r_idx         <= '0;
            r_last        <= 1'b0;
            r_cnt         <= '0;
            r_cmd_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_o_data      <= 8'h00;
            r_o_valid     <= 1'b0;
            r_o_in_ready  <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_ok      <= 1'b0;
            r_rsp_code    <= 8'h00;
            r_rsp_timeout <= 1'b0;
        end else if (clk_en) begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (op_is_valid(bus.cmd_op)) begin
                            r_op        <= w_rom_op;
                            r_idx       <= '0;
                            r_o_data    <= w_char;
                            r_last      <= w_last;
                            r_o_valid   <= 1'b1;
                            r_cmd_ready <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= S_SEND;
                        end else begin
                            r_rsp_valid   <= 1'b1;
                            r_rsp_ok      <= 1'b0;
                            r_rsp_code    <= CH_ERR_E;
                            r_rsp_timeout <= 1'b0;
                        end
                    end
                end
                S_SEND: begin
                    if (bus.i_out_ready) begin
                        if (r_last) begin
                            r_o_valid    <= 1'b0;
                            r_o_in_ready <= 1'b1;
                            r_cnt        <= '0;
                            r_state      <= S_WAIT_RSP;
                        end else begin
                            r_idx    <= w_rom_idx;
                            r_o_data <= w_char;
                            r_last   <= w_last;
                        end
                    end
                end
                S_WAIT_RSP: begin
                    // A reply on the final window cycle beats the timeout
                    if (bus.i_valid) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_ok      <= (bus.i_data == w_ack);
                        r_rsp_code    <= bus.i_data;
                        r_rsp_timeout <= 1'b0;
                        r_o_in_ready  <= 1'b0;
                        r_cmd_ready   <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_ok      <= 1'b0;
                        r_rsp_code    <= 8'h00;
                        r_rsp_timeout <= 1'b1;
                        r_o_in_ready  <= 1'b0;
                        r_cmd_ready   <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.busy        = r_busy;
    assign bus.o_data      = r_o_data;
    assign bus.o_valid     = r_o_valid;
    assign bus.o_in_ready  = r_o_in_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_ok      = r_rsp_ok;
    assign bus.rsp_code    = r_rsp_code;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_bios_host.sv
// Randomised self-checking bench for bios_host against a word/ack reference model.
module tb_bios_host;

    localparam int unsigned TO = 8;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic clk_en = 1'b0;

    bios_host_if u_if ();

    bios_host #(.TIMEOUT_CYCLES(TO)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (u_if.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: command words and acknowledges as plain tables
    function automatic string model_word(input int op);
        case (op)
            0: return "nop";
            1: return "boot";
            2: return "rst";
            3: return "write";
            4: return "read";
            default: return "";
        endcase
    endfunction

    function automatic logic [7:0] model_ack(input int op);
        case (op)
            0: return 8'h4E;
            1: return 8'h42;
            2: return 8'h52;
            3: return 8'h57;
            4: return 8'h52;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, 32'(u_if.cmd_ready), 32'd1);
        chk({tag, "_busy"}, 32'(u_if.busy), 32'd0);
        chk({tag, "_o_valid"}, 32'(u_if.o_valid), 32'd0);
        chk({tag, "_o_data"}, 32'(u_if.o_data), 32'd0);
        chk({tag, "_o_in_ready"}, 32'(u_if.o_in_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(u_if.rsp_valid), 32'd0);
        chk({tag, "_rsp_ok"}, 32'(u_if.rsp_ok), 32'd0);
        chk({tag, "_rsp_code"}, 32'(u_if.rsp_code), 32'd0);
        chk({tag, "_rsp_timeout"}, 32'(u_if.rsp_timeout), 32'd0);
    endtask

    // One command. bp: 0 ready high, 1 pattern 1,0,0, 2 random.
    // en_mode: 0 high, 1 toggling 1,0, 2 random. reply_at: -1 none, else window cycle index.
    task automatic run_cmd(input string tag, input int op, input int bp, input int en_mode,
                           input int reply_at, input logic [7:0] reply_byte);
        string      word = model_word(op);
        int         len  = word.len();
        logic [7:0] got[$];
        bit         accepted = 0, pend = 0, stall_bad = 0, done = 0;
        logic [7:0] pend_data = 8'h00;
        int cyc = 0, accept_cyc = -1, first_valid = -1, first_inrdy = -1;
        int wait_cnt = 0, last_wait_cyc = -1, rsp_first = -1, pulses = 0, post = 0, valid_seen = 0;
        logic       r_ok = 1'b0, r_to = 1'b0, r_rdy = 1'b0;
        logic [7:0] r_code = 8'h00;
        logic       e_ok, e_to;
        logic [7:0] e_code;

        @(negedge clk);
        u_if.cmd_op    = 3'(op);
        u_if.cmd_valid = 1'b1;
        while (!done && cyc < 400) begin
            if (accepted) u_if.cmd_valid = 1'b0;
            case (en_mode)
                0:       clk_en = 1'b1;
                1:       clk_en = (cyc % 2 == 0);
                default: clk_en = 1'($urandom % 2);
            endcase
            case (bp)
                0:       u_if.i_out_ready = 1'b1;
                1:       u_if.i_out_ready = (cyc % 3 == 0);
                default: u_if.i_out_ready = 1'($urandom % 2);
            endcase
            u_if.i_valid = 1'b0;
            u_if.i_data  = 8'($urandom);
            if (u_if.o_in_ready && clk_en && reply_at >= 0 && wait_cnt == reply_at) begin
                u_if.i_valid = 1'b1;
                u_if.i_data  = reply_byte;
            end
            if (u_if.o_valid) begin
                valid_seen++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (pend && (!u_if.o_valid || u_if.o_data !== pend_data)) stall_bad = 1;
            pend      = u_if.o_valid && !(u_if.i_out_ready && clk_en);
            pend_data = u_if.o_data;
            if (u_if.o_valid && u_if.i_out_ready && clk_en) got.push_back(u_if.o_data);
            if (u_if.o_in_ready && first_inrdy < 0) first_inrdy = cyc;
            if (u_if.o_in_ready && clk_en) begin
                wait_cnt++;
                last_wait_cyc = cyc;
            end
            if (u_if.rsp_valid && rsp_first < 0) rsp_first = cyc;
            if (u_if.rsp_valid && clk_en) begin
                pulses++;
                r_ok = u_if.rsp_ok; r_code = u_if.rsp_code; r_to = u_if.rsp_timeout;
                r_rdy = u_if.cmd_ready;
            end
            if (u_if.cmd_valid && u_if.cmd_ready && clk_en && !accepted) begin
                accepted   = 1;
                accept_cyc = cyc;
            end
            if (pulses > 0) begin
                post++;
                if (post > 4) done = 1;
            end
            @(negedge clk);
            cyc++;
        end
        u_if.cmd_valid = 1'b0;
        clk_en = 1'b1;
        chk({tag, "_bound"}, 32'(done), 32'd1);

        if (op > 4) begin
            e_ok = 1'b0; e_code = 8'h45; e_to = 1'b0;
            chk({tag, "_no_valid"}, 32'(valid_seen), 32'd0);
            chk({tag, "_rsp_latency"}, 32'(rsp_first), 32'(accept_cyc + 1));
        end else begin
            if (reply_at >= 0) begin
                e_ok = (reply_byte == model_ack(op)); e_code = reply_byte; e_to = 1'b0;
                chk({tag, "_window"}, 32'(wait_cnt), 32'(reply_at + 1));
            end else begin
                e_ok = 1'b0; e_code = 8'h00; e_to = 1'b1;
                chk({tag, "_window"}, 32'(wait_cnt), 32'(TO));
            end
            chk({tag, "_rsp_latency"}, 32'(rsp_first), 32'(last_wait_cyc + 1));
            chk({tag, "_nbytes"}, 32'(got.size()), 32'(len));
            for (int i = 0; i < len && i < got.size(); i++)
                chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(word[i]));
            chk({tag, "_stall_stable"}, 32'(stall_bad), 32'd0);
            chk({tag, "_first_byte"}, 32'(first_valid), 32'(accept_cyc + 1));
            if (bp == 0 && en_mode == 0)
                chk({tag, "_in_ready_start"}, 32'(first_inrdy), 32'(accept_cyc + len + 1));
        end
        chk({tag, "_pulses"}, 32'(pulses), 32'd1);
        chk({tag, "_cmd_ready_at_rsp"}, 32'(r_rdy), 32'd1);
        chk({tag, "_rsp_ok"}, 32'(r_ok), 32'(e_ok));
        chk({tag, "_rsp_code"}, 32'(r_code), 32'(e_code));
        chk({tag, "_rsp_timeout"}, 32'(r_to), 32'(e_to));
        chk({tag, "_hold"}, {u_if.rsp_ok, u_if.rsp_code, u_if.rsp_timeout, u_if.busy},
            {e_ok, e_code, e_to, 1'b0});
    endtask

    // Abandon a BOOT after its second byte, then confirm reset state and silence.
    task automatic reset_mid_boot();
        int  n = 0, cyc = 0;
        bit  acc = 0, stray = 0;
        @(negedge clk);
        clk_en = 1'b1;
        u_if.i_out_ready = 1'b1;
        u_if.cmd_op      = 3'd1;
        u_if.cmd_valid   = 1'b1;
        while (n < 2 && cyc < 50) begin
            if (acc) u_if.cmd_valid = 1'b0;
            if (u_if.cmd_valid && u_if.cmd_ready) acc = 1;
            if (u_if.o_valid && u_if.i_out_ready) n++;
            @(negedge clk);
            cyc++;
        end
        u_if.cmd_valid = 1'b0;
        chk("rst_mid_bytes", 32'(n), 32'd2);
        chk("rst_mid_busy_before", 32'(u_if.busy), 32'd1);
        rst = 1'b0;
        clk_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        clk_en = 1'b1;
        check_reset_vals("rst_mid");
        for (int i = 0; i < TO + 4; i++) begin
            if (u_if.rsp_valid || u_if.o_valid) stray = 1;
            @(negedge clk);
        end
        chk("rst_mid_silent", 32'(stray), 32'd0);
    endtask

    initial begin
        u_if.cmd_op      = 3'd0;
        u_if.cmd_valid   = 1'b0;
        u_if.i_out_ready = 1'b0;
        u_if.i_data      = 8'h00;
        u_if.i_valid     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        clk_en = 1'b1;

        run_cmd("nop",        0, 0, 0, 2,      8'h4E);
        run_cmd("write_bp",   3, 1, 0, 0,      8'h45);
        run_cmd("read_to",    4, 0, 0, -1,     8'h00);
        run_cmd("read_race",  4, 0, 0, TO - 1, 8'h52);
        run_cmd("invalid6",   6, 0, 0, -1,     8'h00);
        reset_mid_boot();
        run_cmd("nop_after",  0, 0, 0, 1,      8'h4E);
        run_cmd("rst_en_hi",  2, 0, 0, 3,      8'h52);
        run_cmd("rst_en_tgl", 2, 0, 1, 3,      8'h52);
        run_cmd("boot_err_x", 1, 2, 2, 0,      8'h58);

        for (int t = 0; t < 30; t++) begin
            int         op, ra, sel;
            logic [7:0] rb;
            op  = ($urandom % 5 == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
            ra  = int'($urandom_range(0, TO));
            if (ra == TO) ra = -1;
            sel = int'($urandom_range(0, 4));
            case (sel)
                0, 1:    rb = model_ack(op);
                2:       rb = 8'h30;
                3:       rb = 8'h58;
                default: rb = 8'($urandom);
            endcase
            run_cmd($sformatf("rnd%0d", t), op, int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bios_host.md
# bios_host

Host-side command initiator for the BIOS byte-stream command protocol. Accepts a command opcode, serializes the corresponding lowercase ASCII command word onto the outgoing byte stream, then waits for the single-byte reply. It reports success, an error code, or a timeout. It sits between a test/debug controller and the BIOS command parser's stream input/output pair.

## Interface
- `TIMEOUT_CYCLES`, default 1024: clk_en-qualified cycles to wait for a reply before reporting timeout; must be ≥ 2.
- `clk` in, 1: single clock.
- `rst` in, 1: synchronous, active-low reset; takes effect on any `clk` edge with `rst`=0, regardless of `clk_en`.
- `clk_en` in, 1: all state, counter and output updates occur only on edges with `clk_en`=1.
- `cmd_op` in, 3: 0 NOP, 1 BOOT, 2 RST, 3 WRITE, 4 READ; 5–7 invalid.
- `cmd_valid` in, 1; `cmd_ready` out, 1: command handshake.
- `o_data` out, 8: command byte to the BIOS.
- `o_valid` out, 1; `i_out_ready` in, 1: outgoing stream handshake.
- `i_data` in, 8: reply byte from the BIOS.
- `i_valid` in, 1; `o_in_ready` out, 1: incoming stream handshake.
- `rsp_valid` out, 1: one-cycle result strobe.
- `rsp_ok` out, 1: reply matched the expected acknowledge.
- `rsp_code` out, 8: received reply byte; 0x00 on timeout; 0x45 'E' for an invalid opcode.
- `rsp_timeout` out, 1: no reply arrived within `TIMEOUT_CYCLES`.
- `busy` out, 1: high in any state other than IDLE.

## Operation
- **States:** IDLE, SEND, WAIT_RSP.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready` with a valid opcode: latch the opcode, set char index=0, go to SEND.
  - On `cmd_valid`&`cmd_ready` with an invalid opcode: emit no bytes. Next cycle pulse `rsp_valid` with `rsp_ok`=0, `rsp_code`=0x45, `rsp_timeout`=0. Stay in IDLE.
- **Command words and expected acks:**
  - NOP: "nop", ack 'N' (0x4E).
  - BOOT: "boot", ack 'B' (0x42).
  - RST: "rst", ack 'R' (0x52).
  - WRITE: "write", ack 'W' (0x57).
  - READ: "read", ack 'R' (0x52).
- **SEND:**
  - `o_valid`=1, `o_data`=current char.
  - On `o_valid`&`i_out_ready`: increment the index. After the last char, go to WAIT_RSP and clear the timeout counter.
  - `o_data` is held stable while `o_valid`=1 and `i_out_ready`=0.
- **WAIT_RSP:**
  - `o_in_ready`=1; the counter increments on each cycle without a reply.
  - On `i_valid`&`o_in_ready`: capture `i_data` to `rsp_code` and set `rsp_ok`=(`i_data`==expected ack). `rsp_ok`=0 for the error codes '0', 'E', 'X' or any other byte.
  - If the counter reaches `TIMEOUT_CYCLES`-1 with no reply: `rsp_timeout`=1, `rsp_ok`=0, `rsp_code`=0x00.
  - Either outcome: pulse `rsp_valid` and return to IDLE.
- **Simultaneous reply and timeout expiry:** the reply wins and `rsp_timeout`=0.
- **Bytes outside WAIT_RSP:** not accepted (`o_in_ready`=0); the BIOS holds them.
- **Result fields:** `rsp_ok`, `rsp_code` and `rsp_timeout` hold their last values until the next result; only `rsp_valid` is a pulse.
- **Counter width:** $clog2(`TIMEOUT_CYCLES`); the counter never wraps because it is cleared on WAIT_RSP entry.
- **Reset mid-command:** abandons the transfer immediately. `o_valid` drops on the next edge, and no `rsp_valid` is produced for the abandoned command.

## Timing
- **Reset values:**
  - State IDLE, `cmd_ready`=1, `busy`=0.
  - `o_valid`=0, `o_data`=0x00, `o_in_ready`=0.
  - `rsp_valid`=0, `rsp_ok`=0, `rsp_code`=0x00, `rsp_timeout`=0.
- **Command to first byte:** command accepted at edge T; first char valid in cycle T+1.
- **Byte rate:** with `i_out_ready` held high, one char per cycle. A 3-char command occupies cycles T+1..T+3, and `o_in_ready`=1 from T+4.
- **Reply to result:** reply accepted at edge R; `rsp_valid`=1 during cycle R+1 only. `cmd_ready`=1 in that same cycle, so a new command can be accepted at edge R+1.
- **Timeout:** `rsp_valid` rises exactly `TIMEOUT_CYCLES` clk_en cycles after WAIT_RSP entry when no byte arrives.
- **clk_en low:** every output freezes, including `rsp_valid`; the pulse lasts one clk_en-qualified cycle.

## Structure
- **Shared types package:** opcode enum `bios_op_t`, the ASCII constants (lowercase letters, 'N', 'B', 'R', 'W', '0', 'E', 'X'), and the ack-per-opcode function. These are shared with the BIOS parser.
- **Sub-module `bios_cmd_rom`:** combinational. Inputs are opcode and 3-bit char index; outputs are the char, a last-char flag, and the expected ack.
- **Main FSM:** the timeout counter and the result registers live in `bios_host`.

## Test plan
- **NOP, ready held high:** expect 0x6E, 0x6F, 0x70 on three consecutive cycles. Reply 0x4E -> `rsp_valid` one cycle, `rsp_ok`=1, `rsp_code`=0x4E.
- **WRITE with backpressure:** toggle `i_out_ready` 1,0,0,1,…; expect "write" with `o_data` stable during stalls. Reply 0x45 -> `rsp_ok`=0, `rsp_code`=0x45.
- **Timeout:** `TIMEOUT_CYCLES`=8, READ, no reply -> `rsp_timeout`=1 and `rsp_code`=0x00 exactly 8 cycles after the last byte handshake.
- **Race:** reply arrives on the final timeout cycle -> `rsp_timeout`=0 and the reply is reported.
- **Invalid opcode:** `cmd_op`=6 -> no `o_valid` activity; `rsp_valid` next cycle with `rsp_code`=0x45.
- **Reset and clk_en:**
  - Reset after the 2nd byte of BOOT -> all outputs at reset values and no `rsp_valid`; a following NOP completes normally.
  - `clk_en` toggling 1,0 throughout RST -> same byte sequence and result as with `clk_en` held high.
